// File: rtl/cnn_frame_sequencer_if.sv
// Pixel stream, CNN core and result handshake bundle for cnn_frame_sequencer.
// master = sequencer side, slave = upstream source / core / result consumer side.
interface cnn_frame_sequencer_if #(
    parameter int PIX_W   = 32,
    parameter int N_CLASS = 10
);
    logic [PIX_W-1:0]   src_data;
    logic               src_valid;
    logic               src_last;
    logic               src_ready;
    logic               cnn_start;
    logic [PIX_W-1:0]   cnn_din;
    logic               cnn_din_ready;
    logic               cnn_conv1_done;
    logic               cnn_done;
    logic [N_CLASS-1:0] cnn_classes;
    logic               res_valid;
    logic               res_ready;
    logic [3:0]         res_class;
    logic [N_CLASS-1:0] res_onehot;

    modport master (
        input  src_data, src_valid, src_last, cnn_din_ready, cnn_conv1_done,
               cnn_done, cnn_classes, res_ready,
        output src_ready, cnn_start, cnn_din, res_valid, res_class, res_onehot
    );

    modport slave (
        output src_data, src_valid, src_last, cnn_din_ready, cnn_conv1_done,
               cnn_done, cnn_classes, res_ready,
        input  src_ready, cnn_start, cnn_din, res_valid, res_class, res_onehot
    );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// Frame-level controller for CNN_top: paces one frame of pixels into the core,
// waits for the classification and hands the class index out with sticky error flags.
module cnn_frame_sequencer #(
    parameter int PIX_W   = 32,
    parameter int N_PIX   = 784,
    parameter int N_CLASS = 10,
    parameter int TIMEOUT = 1048576
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  err_clr,
    cnn_frame_sequencer_if.master bus,
    output logic                  err_underrun,
    output logic                  err_length,
    output logic                  err_timeout,
    output logic                  err_multihot,
    output logic [15:0]           frame_cnt,
    output logic                  busy
);
    localparam int CW = $clog2(N_PIX + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] PIX_END  = CW'(N_PIX);
    localparam logic [CW-1:0] PIX_LAST = CW'(N_PIX - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, START, LOAD, WAIT, RESULT} state_t;
    state_t state, state_nx;

    logic [CW-1:0]      pix_cnt;
    logic [TW-1:0]      tmo;
    logic               pad;
    logic               start_q;
    logic [PIX_W-1:0]   din_q;
    logic [N_CLASS-1:0] onehot_q;
    logic [3:0]         class_c;
    logic slot, take, early_last, got_done, tmo_hit;
    logic set_und, set_len, set_mh;

    always_comb begin
        slot       = (state == LOAD) && bus.cnn_din_ready && (pix_cnt < PIX_END);
        take       = slot && !pad && bus.src_valid;
        early_last = take && bus.src_last && (pix_cnt < PIX_LAST);
        got_done   = (state == WAIT) && bus.cnn_done;
        tmo_hit    = (state == WAIT) && !bus.cnn_done && (tmo == TMO_LAST);
        // the core cannot stall, so a missing pixel still burns its slot
        set_und    = slot && !pad && !bus.src_valid;
        set_len    = early_last || (take && !bus.src_last && (pix_cnt == PIX_LAST));
        set_mh     = got_done && |(bus.cnn_classes & (bus.cnn_classes - N_CLASS'(1)));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable) state_nx = START;
            START:   state_nx = LOAD;
            LOAD:    if (slot && pix_cnt == PIX_LAST) state_nx = WAIT;
            WAIT:    if (got_done || tmo_hit) state_nx = RESULT;
            RESULT:  if (bus.res_ready) state_nx = enable ? START : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        class_c = 4'hF;
        for (int i = N_CLASS - 1; i >= 0; i--)
            if (onehot_q[i]) class_c = 4'(i);
    end

    assign bus.src_ready  = slot && !pad;
    assign bus.cnn_start  = start_q;
    assign bus.cnn_din    = din_q;
    assign bus.res_valid  = (state == RESULT);
    assign bus.res_class  = class_c;
    assign bus.res_onehot = onehot_q;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt   <= '0;
            tmo       <= '0;
            pad       <= 1'b0;
            start_q   <= 1'b0;
            din_q     <= '0;
            onehot_q  <= '0;
            frame_cnt <= '0;
        end else begin
            if (state == START) begin
                pix_cnt <= '0;
                tmo     <= '0;
                pad     <= 1'b0;
            end
            if (slot) begin
                pix_cnt <= pix_cnt + CW'(1);
                din_q   <= take ? bus.src_data : '0;
            end
            if (early_last)    pad <= 1'b1;
            if (state == WAIT) tmo <= tmo + TW'(1);
            if (got_done)      onehot_q <= bus.cnn_classes;
            else if (tmo_hit)  onehot_q <= '0;
            if (state_nx == START)
                start_q <= 1'b1;
            else if (bus.cnn_conv1_done || state_nx == RESULT)
                start_q <= 1'b0;
            if (state == RESULT && bus.res_ready) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // a set event in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_underrun <= 1'b0;
            err_length   <= 1'b0;
            err_timeout  <= 1'b0;
            err_multihot <= 1'b0;
        end else begin
            if (set_und)      err_underrun <= 1'b1;
            else if (err_clr) err_underrun <= 1'b0;
            if (set_len)      err_length   <= 1'b1;
            else if (err_clr) err_length   <= 1'b0;
            if (tmo_hit)      err_timeout  <= 1'b1;
            else if (err_clr) err_timeout  <= 1'b0;
            if (set_mh)       err_multihot <= 1'b1;
            else if (err_clr) err_multihot <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed frame scenarios with randomized core pacing and pixel data, checked
// against a slot-level reference model of the sequencer's frame rules.
module tb_cnn_frame_sequencer;
    localparam int PIX_W   = 32;
    localparam int N_PIX   = 784;
    localparam int N_CLASS = 10;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             last;
    } pix_t;

    logic clk = 1'b0;
    logic rst, enable, err_clr;
    logic err_underrun, err_length, err_timeout, err_multihot;
    logic [15:0] frame_cnt;
    logic busy;

    cnn_frame_sequencer_if #(.PIX_W(PIX_W), .N_CLASS(N_CLASS)) bus ();

    cnn_frame_sequencer #(
        .PIX_W(PIX_W), .N_PIX(N_PIX), .N_CLASS(N_CLASS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr), .bus(bus.master),
        .err_underrun(err_underrun), .err_length(err_length), .err_timeout(err_timeout),
        .err_multihot(err_multihot), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    pix_t src_q[$];
    logic [PIX_W-1:0] exp_din[$];
    logic [PIX_W-1:0] obs_din[$];
    bit m_und, m_len, m_tmo, m_mh;
    int m_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int lowest(input logic [N_CLASS-1:0] v);
        for (int i = 0; i < N_CLASS; i++) if (v[i]) return i;
        return 15;
    endfunction

    task automatic idle_in();
        bus.cnn_din_ready  = 1'b0;
        bus.src_valid      = 1'b0;
        bus.src_last       = 1'b0;
        bus.cnn_conv1_done = 1'b0;
        bus.cnn_done       = 1'b0;
        err_clr            = 1'b0;
    endtask

    task automatic push_frame(input int n, input bit ramp);
        pix_t p;
        for (int i = 0; i < n; i++) begin
            p.data = ramp ? 32'(i) : 32'($urandom);
            p.last = (i == n - 1);
            src_q.push_back(p);
        end
    endtask

    task automatic check_reset();
        chk("rst_cnn_start", bus.cnn_start, 0);
        chk("rst_cnn_din", bus.cnn_din, 0);
        chk("rst_src_ready", bus.src_ready, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_class", bus.res_class, 4'hF);
        chk("rst_res_onehot", bus.res_onehot, 0);
        chk("rst_errs", {err_underrun, err_length, err_timeout, err_multihot}, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic wait_start();
        int n = 0;
        while (bus.cnn_start !== 1'b1 && n < 20) begin
            @(negedge clk); idle_in(); #1; n++;
        end
        chk("start_seen", bus.cnn_start, 1);
    endtask

    // Called in the START cycle; returns in the first WAIT cycle (or early on abort).
    task automatic load_frame(input int ur_at, input int ur_len, input int abort_at, input bit c1);
        int k = 0, cyc = 0, rdy_err = 0, st_err = 0, nmis = 0;
        bit pad = 0, slot_prev = 0, dr, exp_rdy, exp_st;
        exp_din.delete(); obs_din.delete();
        wait_start();
        while (k < N_PIX) begin
            @(negedge clk);
            if (slot_prev) obs_din.push_back(bus.cnn_din);
            if (k == abort_at) return;
            idle_in(); bus.res_ready = 1'b0;
            dr = ($urandom_range(0, 3) != 0);
            bus.cnn_din_ready  = dr;
            bus.cnn_conv1_done = c1 && (cyc == 3);
            bus.cnn_done       = (cyc == 10);
            bus.cnn_classes    = '1;
            exp_rdy = 1'b0;
            if (src_q.size() > 0) begin
                bus.src_data = src_q[0].data;
                bus.src_last = src_q[0].last;
            end
            if (!dr) begin
                bus.src_valid = ($urandom_range(0, 1) == 1) && (src_q.size() > 0);
            end else if (pad) begin
                bus.src_valid = (src_q.size() > 0);
                exp_din.push_back('0);
            end else if ((k >= ur_at && k < ur_at + ur_len) || src_q.size() == 0) begin
                exp_rdy = 1'b1; m_und = 1'b1;
                exp_din.push_back('0);
            end else begin
                bus.src_valid = 1'b1; exp_rdy = 1'b1;
                exp_din.push_back(src_q[0].data);
                if (src_q[0].last && k < N_PIX - 1) begin pad = 1'b1; m_len = 1'b1; end
                if (!src_q[0].last && k == N_PIX - 1) m_len = 1'b1;
                void'(src_q.pop_front());
            end
            if (dr) k++;
            #1;
            if (bus.src_ready !== exp_rdy) rdy_err++;
            exp_st = !(c1 && cyc >= 4);
            if (bus.cnn_start !== exp_st) st_err++;
            slot_prev = dr;
            cyc++;
        end
        @(negedge clk);
        obs_din.push_back(bus.cnn_din);
        idle_in(); bus.res_ready = 1'b0;
        #1;
        for (int i = 0; i < N_PIX && i < obs_din.size(); i++)
            if (obs_din[i] !== exp_din[i]) nmis++;
        chk("din_count", obs_din.size(), N_PIX);
        chk("din_mismatches", nmis, 0);
        chk("src_ready_errs", rdy_err, 0);
        chk("cnn_start_errs", st_err, 0);
        chk("wait_res_valid", bus.res_valid, 0);
        chk("err_underrun", err_underrun, m_underrun_v());
        chk("err_length", err_length, m_len);
    endtask

    function automatic bit m_underrun_v();
        return m_und;
    endfunction

    // d = WAIT cycle in which done is driven (0 = never); clr_at = WAIT cycle of an err_clr pulse.
    task automatic finish_frame(input int d, input logic [N_CLASS-1:0] cls, input int hold, input int clr_at);
        int s = 0, lat = 0, vcnt = 1, guard = 0;
        bit hs = 0;
        logic [N_CLASS-1:0] eoh;
        while (lat == 0 && s < TIMEOUT + 10) begin
            @(negedge clk); s++;
            idle_in();
            bus.res_ready   = (hold == 0);
            bus.cnn_done    = (d != 0 && s == d);
            bus.cnn_classes = (s == d) ? cls : ~cls;
            if (s == clr_at) begin
                err_clr = 1'b1;
                m_und = 0; m_len = 0; m_tmo = 0; m_mh = 0;
            end
            #1;
            if (bus.res_valid) lat = s;
        end
        if (d == 0) begin
            m_tmo = 1'b1; eoh = '0;
        end else begin
            eoh = cls;
            if ($countones(cls) > 1) m_mh = 1'b1;
        end
        chk("result_latency", lat, (d == 0) ? TIMEOUT : d + 1);
        chk("res_onehot", bus.res_onehot, eoh);
        chk("res_class", bus.res_class, lowest(eoh));
        chk("start_low_in_result", bus.cnn_start, 0);
        chk("flags_at_result", {err_underrun, err_length, err_timeout, err_multihot},
            {m_und, m_len, m_tmo, m_mh});
        while (!hs && guard < hold + 5) begin
            @(negedge clk); guard++;
            idle_in(); bus.res_ready = 1'b0;
            if (!bus.res_valid) hs = 1'b1;
            else begin
                vcnt++;
                bus.res_ready = (vcnt > hold);
            end
            #1;
        end
        m_fc++;
        chk("res_valid_cycles", vcnt, hold + 1);
        chk("frame_cnt", frame_cnt, m_fc);
        chk("busy_after_accept", busy, enable);
        chk("restart_after_accept", bus.cnn_start, enable);
    endtask

    initial begin
        logic [N_CLASS-1:0] cls;
        rst = 1'b1; enable = 1'b0;
        idle_in();
        bus.res_ready = 1'b0; bus.src_data = '0; bus.cnn_classes = '0;
        m_und = 0; m_len = 0; m_tmo = 0; m_mh = 0; m_fc = 0;
        repeat (3) @(negedge clk);
        #1;
        check_reset();
        @(negedge clk); rst = 1'b0; #1;
        @(negedge clk); enable = 1'b1; #1;
        chk("start_before_enable_edge", bus.cnn_start, 0);
        chk("busy_idle", busy, 0);
        @(negedge clk); #1;
        chk("start_latency", bus.cnn_start, 1);
        chk("busy_start", busy, 1);

        // nominal frame, ramp pixels, class 3
        push_frame(N_PIX, 1'b1);
        load_frame(-1, 0, -1, 1'b1);
        finish_frame(5, 10'b0000001000, 0, 0);

        // underrun: 5 empty slots at pixel 100, upstream frame is 5 shorter
        push_frame(N_PIX - 5, 1'b0);
        load_frame(100, 5, -1, 1'b1);
        cls = N_CLASS'(1) << $urandom_range(0, N_CLASS - 1);
        finish_frame($urandom_range(1, 30), cls, 2, 1);

        // early last at 500, surplus frame queued behind it; done on the final WAIT cycle
        push_frame(501, 1'b0);
        push_frame(N_PIX, 1'b0);
        load_frame(-1, 0, -1, 1'b1);
        cls = N_CLASS'(1) << $urandom_range(0, N_CLASS - 1);
        finish_frame(TIMEOUT - 1, cls, 1, 1);

        // surplus frame, core never reports done
        load_frame(-1, 0, -1, 1'b0);
        finish_frame(0, 10'h3FF, 3, 0);

        // multi-hot with backpressure; enable dropped mid-frame; clear collides with set
        enable = 1'b0;
        push_frame(N_PIX, 1'b0);
        load_frame(-1, 0, -1, 1'b1);
        finish_frame(7, 10'b1000100000, 7, 7);
        repeat (3) begin
            @(negedge clk); idle_in(); #1;
        end
        chk("stays_idle_busy", busy, 0);
        chk("stays_idle_start", bus.cnn_start, 0);

        // reset in the middle of LOAD
        enable = 1'b1;
        push_frame(N_PIX, 1'b0);
        load_frame(-1, 0, 300, 1'b1);
        rst = 1'b1;
        idle_in();
        #1;
        check_reset();
        m_und = 0; m_len = 0; m_tmo = 0; m_mh = 0; m_fc = 0;
        src_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_frame(N_PIX, 1'b1);
        load_frame(-1, 0, -1, 1'b1);
        finish_frame(3, 10'b1000000000, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cnn_frame_sequencer.md
# cnn_frame_sequencer

Frame-level controller in front of `CNN_top`: runs back-to-back inferences without a testbench driving the core. It:
- pulls 784-pixel frames from an upstream valid/ready stream and paces them into the core's `din`/`din_ready` interface;
- generates `start` and retires it on `conv1_done`;
- waits for `done`, then converts the 10-bit `classes` vector into a class index with a result handshake and sticky error reporting.

## Interface
- PIX_W, 32, pixel width (matches core `din`)
- N_PIX, 784, pixels per frame
- N_CLASS, 10, width of core `classes`
- TIMEOUT, 1048576, max cycles in WAIT before abort
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; 1 = keep starting frames
- err_clr  in  1  pulse; clears all sticky error flags
- src_data  in  PIX_W  upstream pixel
- src_valid  in  1  upstream pixel valid
- src_last  in  1  marks final pixel of a frame
- src_ready  out  1  pixel consumed this cycle
- cnn_start  out  1  to core `start`
- cnn_din  out  PIX_W  to core `din`, registered
- cnn_din_ready  in  1  from core `din_ready`
- cnn_conv1_done  in  1  from core `conv1_done`
- cnn_done  in  1  from core `done`
- cnn_classes  in  N_CLASS  from core `classes`
- res_valid  out  1  result available
- res_ready  in  1  result accepted
- res_class  out  4  class index 0..9; 4'hF = none/abort
- res_onehot  out  N_CLASS  captured `classes`
- err_underrun / err_length / err_timeout / err_multihot  out  1 each  sticky flags
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0
- busy  out  1  state != IDLE

## Operation
- States: IDLE, START, LOAD, WAIT, RESULT.
- IDLE -> START when enable=1.
- START:
  - asserts cnn_start, clears pix_cnt and the timeout counter;
  - moves to LOAD the next cycle.
- cnn_start:
  - set on entry to START;
  - cleared the cycle after cnn_conv1_done is sampled high, or on entry to RESULT, whichever is first.
- LOAD, pixel slot = cycle where cnn_din_ready=1 and pix_cnt<N_PIX:
  - src_ready = slot && !pad (combinational).
  - If src_valid: cnn_din <= src_data.
  - If !src_valid: cnn_din <= 0 and err_underrun <= 1. The core cannot stall, so the slot is consumed anyway.
  - Every slot increments pix_cnt; cnn_din holds between slots.
- src_last checks:
  - src_last=1 on a consumed pixel with index < N_PIX-1: err_length <= 1, pad <= 1. Remaining slots of the frame feed 0, no upstream consumption, no underrun flag.
  - src_last=0 on pixel N_PIX-1: err_length <= 1. Surplus upstream pixels are taken as the next frame.
- LOAD -> WAIT when pix_cnt reaches N_PIX.
- WAIT: the timeout counter increments every cycle.
  - cnn_done=1: capture cnn_classes into res_onehot, go to RESULT.
  - Counter reaches TIMEOUT-1 with no done: err_timeout <= 1, res_onehot <= 0, go to RESULT.
- Class encoding:
  - res_class = index of the lowest set bit of res_onehot; 4'hF if zero.
  - popcount > 1 sets err_multihot.
- RESULT: res_valid=1 until res_ready=1.
  - On accept: frame_cnt++.
  - Then go to START if enable=1, else IDLE.
- cnn_done outside WAIT is ignored. enable is sampled only in IDLE and on result accept; dropping it mid-frame completes the frame.
- err_clr clears the flags. A set event in the same cycle wins over clear.

## Timing
- All outputs zero on reset except res_class=4'hF. State = IDLE, pad=0.
- Reset is asynchronous at any point, including mid-LOAD: the frame is abandoned and frame_cnt returns to 0.
- cnn_start is high 1 cycle after enable is sampled in IDLE.
- Pixel written at the slot edge reaches cnn_din one cycle after the core's din_ready.
- Capture: cnn_done high at edge t -> res_valid, res_class and res_onehot valid at t+1.
- res_valid && res_ready at edge t -> START at t+1 (enable=1); busy stays 1.
- Minimum RESULT dwell is 1 cycle.

## Test plan
- Nominal frame: enable=1, 784 valid pixels 0..783 with src_last on the last, core asserts done with classes=10'b0000001000 -> res_class=3, frame_cnt=1, no errors; cnn_din sequence equals the pixel sequence.
- Underrun: src_valid low for 5 slots at pixel 100 -> err_underrun=1, pixel count still 784, those slots drive cnn_din=0, LOAD exits after 784 slots.
- Early last: src_last at index 500 -> err_length=1, slots 501..783 feed 0 with src_ready=0, next frame begins with the next upstream pixel.
- Timeout: TIMEOUT=64, core never asserts done -> after 64 WAIT cycles err_timeout=1, res_class=4'hF, res_onehot=0.
- Multi-hot plus backpressure: classes=10'b1000100000, res_ready low 7 cycles -> res_class=5, err_multihot=1, res_valid held 8 cycles, single frame_cnt increment.
- Reset mid-LOAD at pixel 300, then re-enable -> all outputs at reset values, fresh frame counts from pixel 0, cnn_start re-asserts.
